// File: rtl/map_writer_pkg.sv
// map_writer_pkg: shared encodings and defaults for the card-map writer.
// Holds op codes, FSM states, table geometry defaults and slot indexing.
package map_writer_pkg;

  localparam int COLS_DEF   = 18;
  localparam int ROWS_DEF   = 8;
  localparam int CARD_W_DEF = 6;
  localparam int EMPTY_CARD = 0;

  typedef enum logic [1:0] {
    OP_SET       = 2'b00,
    OP_CLEAR     = 2'b01,
    OP_MOVE      = 2'b10,
    OP_CLEAR_ROW = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ROW  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Slot index x + y*cols, kept at 8 bits so all 144 slots fit.
  function automatic logic [7:0] slot_idx(
    input logic [4:0] x,
    input logic [2:0] y,
    input int         cols
  );
    return {3'b000, x} + ({5'b00000, y} * 8'(cols));
  endfunction

endpackage

// File: rtl/map_writer.sv
// map_writer: request-driven editor for a flat card table.
// Optional MAP_DOUBLE_BUFFER_EN adds a frame-synchronous display copy.
module map_writer
  import map_writer_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int CARD_W = CARD_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    op,
  input  logic [4:0]                    src_x,
  input  logic [2:0]                    src_y,
  input  logic [4:0]                    dst_x,
  input  logic [2:0]                    dst_y,
  input  logic [CARD_W-1:0]             card_in,
  input  logic                          frame_start,
  output logic [ROWS*COLS*CARD_W-1:0]   map,
  output logic                          done,
  output logic                          err
);

  localparam int SLOTS = ROWS * COLS;
  localparam logic [CARD_W-1:0] EMPTY =
    CARD_W'(EMPTY_CARD);

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [4:0]        r_src_x;
  logic [2:0]        r_src_y;
  logic [4:0]        r_dst_x;
  logic [2:0]        r_dst_y;
  logic [CARD_W-1:0] r_card;
  logic [4:0]        r_col;
  logic              r_rej;
  logic [CARD_W-1:0] r_tab [SLOTS];

  logic              w_accept;
  logic [7:0]        w_src_idx;
  logic [7:0]        w_dst_idx;
  logic [7:0]        w_row_idx;
  logic              w_src_ok;
  logic              w_dst_ok;
  logic              w_row_ok;
  logic              w_same;
  logic [CARD_W-1:0] w_src_card;
  logic [CARD_W-1:0] w_dst_card;
  logic              w_rej;
  logic              w_col_last;

  assign w_accept  = req_valid &&
                     (r_state == ST_IDLE);
  assign w_src_idx = slot_idx(r_src_x, r_src_y, COLS);
  assign w_dst_idx = slot_idx(r_dst_x, r_dst_y, COLS);
  assign w_row_idx = slot_idx(r_col, r_dst_y, COLS);

  assign w_src_ok = (int'(r_src_x) < COLS) &&
                    (int'(r_src_y) < ROWS);
  assign w_dst_ok = (int'(r_dst_x) < COLS) &&
                    (int'(r_dst_y) < ROWS);
  assign w_row_ok = (int'(r_dst_y) < ROWS);
  assign w_same   = (r_src_x == r_dst_x) &&
                    (r_src_y == r_dst_y);

  assign w_src_card = w_src_ok ?
                      r_tab[w_src_idx] : EMPTY;
  assign w_dst_card = w_dst_ok ?
                      r_tab[w_dst_idx] : EMPTY;

  assign w_col_last = (int'(r_col) == COLS - 1);

  // Decide whether the latched request must be refused.
  always_comb begin
    w_rej = 1'b0;
    unique case (r_op)
      OP_MOVE:
        w_rej = !w_src_ok || !w_dst_ok || w_same ||
                (w_src_card == EMPTY) ||
                (w_dst_card != EMPTY);
      OP_CLEAR_ROW:
        w_rej = !w_row_ok;
      default:
        w_rej = !w_dst_ok;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept)
          w_next = (op_e'(op) == OP_CLEAR_ROW) ?
                   ST_ROW : ST_EXEC;
      end
      ST_EXEC: w_next = ST_DONE;
      ST_ROW:  if (w_col_last) w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        err    = r_rej;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request operands on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= OP_SET;
      r_src_x <= '0;
      r_src_y <= '0;
      r_dst_x <= '0;
      r_dst_y <= '0;
      r_card  <= '0;
    end else if (w_accept) begin
      r_op    <= op_e'(op);
      r_src_x <= src_x;
      r_src_y <= src_y;
      r_dst_x <= dst_x;
      r_dst_y <= dst_y;
      r_card  <= card_in;
    end
  end

  // Working table writes, row sweep and reject flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_rej <= 1'b0;
      for (int i = 0; i < SLOTS; i++)
        r_tab[i] <= EMPTY;
    end else begin
      if (w_accept) r_col <= '0;
      if (r_state == ST_EXEC) begin
        r_rej <= w_rej;
        if (!w_rej) begin
          unique case (r_op)
            OP_SET:   r_tab[w_dst_idx] <= r_card;
            OP_CLEAR: r_tab[w_dst_idx] <= EMPTY;
            OP_MOVE: begin
              r_tab[w_dst_idx] <= w_src_card;
              r_tab[w_src_idx] <= EMPTY;
            end
            default: ;
          endcase
        end
      end
      if (r_state == ST_ROW) begin
        r_rej <= w_rej;
        if (!w_rej) r_tab[w_row_idx] <= EMPTY;
        r_col <= r_col + 5'd1;
      end
    end
  end

`ifdef MAP_DOUBLE_BUFFER_EN
  logic [CARD_W-1:0] r_disp [SLOTS];

  // Display copy commits only at a frame edge while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++)
        r_disp[i] <= EMPTY;
    end else if (frame_start &&
                 (r_state == ST_IDLE)) begin
      r_disp <= r_tab;
    end
  end

  // Flatten the display copy onto the map bus.
  always_comb begin
    map = '0;
    for (int i = 0; i < SLOTS; i++)
      map[i*CARD_W +: CARD_W] = r_disp[i];
  end
`else
  logic w_unused;
  assign w_unused = frame_start;

  // Flatten the working table onto the map bus.
  always_comb begin
    map = '0;
    for (int i = 0; i < SLOTS; i++)
      map[i*CARD_W +: CARD_W] = r_tab[i];
  end
`endif

endmodule

// File: tb/tb_map_writer.sv
// tb_map_writer: randomized and directed bench for map_writer.
// Works with and without MAP_DOUBLE_BUFFER_EN.
module tb_map_writer;
  import map_writer_pkg::*;

  localparam int COLS  = 18;
  localparam int ROWS  = 8;
  localparam int CW    = 6;
  localparam int SLOTS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic frame_start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [4:0] src_x = '0;
  logic [2:0] src_y = '0;
  logic [4:0] dst_x = '0;
  logic [2:0] dst_y = '0;
  logic [CW-1:0] card_in = '0;
  logic req_ready;
  logic done;
  logic err;
  logic [SLOTS*CW-1:0] map;

  int errors = 0;
  int checks = 0;
  bit fs_en  = 1'b0;

  int m_new  [SLOTS];
  int m_old  [SLOTS];
  int m_disp [SLOTS];
  int m_act  = 0;
  int m_age  = 0;
  int m_lat  = 1;
  int m_rej  = 0;
  int m_op   = 0;
  int m_dy   = 0;
  bit m_init = 1'b0;

  always #5 clk = ~clk;

  map_writer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .op          (op),
    .src_x       (src_x),
    .src_y       (src_y),
    .dst_x       (dst_x),
    .dst_y       (dst_y),
    .card_in     (card_in),
    .frame_start (frame_start),
    .map         (map),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int slot(input int i);
    return int'(map[i*CW +: CW]);
  endfunction

  // Working-table content the spec says is visible now.
  function automatic int exp_slot(input int i);
    if (m_act == 0) return m_new[i];
    if (m_op != 3) return (m_age == 0) ? m_old[i] : m_new[i];
    if (m_rej == 0 && (i / COLS) == m_dy &&
        (i % COLS) < m_age)
      return 0;
    return m_old[i];
  endfunction

  task automatic model_accept();
    int si;
    int di;
    si = int'(src_x) + int'(src_y) * COLS;
    di = int'(dst_x) + int'(dst_y) * COLS;
    m_old = m_new;
    m_op  = int'(op);
    m_dy  = int'(dst_y);
    m_act = 1;
    m_age = 0;
    m_rej = 0;
    m_lat = (m_op == 3) ? 18 : 1;
    case (m_op)
      0, 1: begin
        if (int'(dst_x) >= COLS) m_rej = 1;
        else m_new[di] = (m_op == 0) ? int'(card_in) : 0;
      end
      2: begin
        if (int'(src_x) >= COLS || int'(dst_x) >= COLS ||
            si == di || m_old[si] == 0 || m_old[di] != 0)
          m_rej = 1;
        else begin
          m_new[di] = m_old[si];
          m_new[si] = 0;
        end
      end
      default: begin
        for (int c = 0; c < COLS; c++)
          m_new[m_dy*COLS + c] = 0;
      end
    endcase
  endtask

  // Reference model, advanced once per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < SLOTS; i++) begin
          m_new[i]  = 0;
          m_old[i]  = 0;
          m_disp[i] = 0;
        end
        m_act  = 0;
        m_init = 1'b1;
      end else if (m_init) begin
        if (frame_start && m_act == 0) m_disp = m_new;
        if (m_act != 0) begin
          m_age++;
          if (m_age > m_lat) m_act = 0;
        end else if (req_valid) begin
          model_accept();
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin : cmp
        int bad;
        int e;
        int d;
        bad = -1;
        for (int i = 0; i < SLOTS; i++) begin
`ifdef MAP_DOUBLE_BUFFER_EN
          e = m_disp[i];
`else
          e = exp_slot(i);
`endif
          if (bad < 0 && slot(i) != e) begin
            bad = i;
            d = e;
          end
        end
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL map slot=%0d act=%0d exp=%0d t=%0t",
                   bad, slot(bad), d, $time);
        end
        d = (m_act != 0 && m_age == m_lat) ? 1 : 0;
        chk("req_ready", int'(req_ready), (m_act == 0) ? 1 : 0);
        chk("done", int'(done), d);
        chk("err", int'(err), (d == 1 && m_rej != 0) ? 1 : 0);
      end
    end
  end

  // Random frame pulses, only in the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (fs_en) frame_start = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_wait act=0 exp=1 t=%0t", $time);
    end
  endtask

  task automatic issue(input int o,
                       input int sx, input int sy,
                       input int dx, input int dy,
                       input int c);
    wait_ready();
    op        = 2'(o);
    src_x     = 5'(sx);
    src_y     = 3'(sy);
    dst_x     = 5'(dx);
    dst_y     = 3'(dy);
    card_in   = CW'(c);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run(input int o,
                     input int sx, input int sy,
                     input int dx, input int dy,
                     input int c);
    issue(o, sx, sy, dx, dy, c);
    wait_ready();
  endtask

  initial begin : main
    int k;
    int r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_map_zero", int'(map == '0), 1);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);

    issue(0, 0, 0, 3, 2, 'h15);
    @(negedge clk);
    chk("set_age0_done", int'(done), 0);
`ifndef MAP_DOUBLE_BUFFER_EN
    chk("set_age0_slot39", slot(39), 0);
`endif
    @(negedge clk);
`ifndef MAP_DOUBLE_BUFFER_EN
    chk("set_slot39", slot(39), 'h15);
`endif
    chk("set_done", int'(done), 1);
    chk("set_err", int'(err), 0);
    @(negedge clk);
    chk("set_ready_back", int'(req_ready), 1);

    issue(2, 3, 2, 0, 7, 0);
    @(negedge clk);
    @(negedge clk);
    chk("move_done", int'(done), 1);
    chk("move_err", int'(err), 0);
`ifndef MAP_DOUBLE_BUFFER_EN
    chk("move_slot126", slot(126), 'h15);
    chk("move_slot39", slot(39), 0);
`endif
    @(negedge clk);
    issue(2, 3, 2, 0, 7, 0);
    @(negedge clk);
    @(negedge clk);
    chk("move2_err", int'(err), 1);
`ifndef MAP_DOUBLE_BUFFER_EN
    chk("move2_slot126", slot(126), 'h15);
`endif
    @(negedge clk);

    issue(0, 0, 0, 18, 0, 5);
    @(negedge clk);
    @(negedge clk);
    chk("x18_done", int'(done), 1);
    chk("x18_err", int'(err), 1);
`ifndef MAP_DOUBLE_BUFFER_EN
    chk("x18_slot18", slot(18), 0);
`endif
    @(negedge clk);

    for (int c = 0; c < COLS; c++) run(0, 0, 0, c, 2, c + 1);
    run(0, 0, 0, 17, 1, 'h2A);
    run(0, 0, 0, 0, 3, 'h3F);
    issue(3, 0, 0, 0, 2, 0);
    k = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      k = n;
      if (done) break;
      chk("row_ready_low", int'(req_ready), 0);
    end
    chk("row_latency", k, 19);
`ifndef MAP_DOUBLE_BUFFER_EN
    for (int s = 36; s <= 53; s++) chk("row_cleared", slot(s), 0);
    chk("row_keep35", slot(35), 'h2A);
    chk("row_keep54", slot(54), 'h3F);
    chk("row_keep126", slot(126), 'h15);
`endif
    @(negedge clk);

    for (int c = 0; c < 8; c++) run(0, 0, 0, c, 4, c + 'h20);
    issue(3, 0, 0, 0, 4, 0);
    repeat (6) @(negedge clk);
`ifndef MAP_DOUBLE_BUFFER_EN
    chk("rowrst_col4", slot(76), 0);
    chk("rowrst_col5", slot(77), 'h25);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rowrst_map_zero", int'(map == '0), 1);
    chk("rowrst_done", int'(done), 0);
    chk("rowrst_ready", int'(req_ready), 1);
    @(negedge clk);
    chk("rowrst_ready2", int'(req_ready), 1);
    chk("rowrst_done2", int'(done), 0);

`ifdef MAP_DOUBLE_BUFFER_EN
    run(0, 0, 0, 1, 0, 'h11);
    repeat (3) @(negedge clk);
    chk("db_no_frame", slot(1), 0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("db_frame_idle", slot(1), 'h11);
    run(1, 0, 0, 1, 0, 0);
    issue(3, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("db_frame_row", slot(1), 'h11);
    wait_ready();
    chk("db_after_row", slot(1), 'h11);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("db_commit", slot(1), 0);
`endif

    fs_en = 1'b1;
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      issue((r < 4) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3,
            $urandom_range(0, 19), $urandom_range(0, 7),
            $urandom_range(0, 19), $urandom_range(0, 7),
            $urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        op      = 2'($urandom_range(0, 3));
        src_x   = 5'($urandom_range(0, 31));
        dst_x   = 5'($urandom_range(0, 31));
        dst_y   = 3'($urandom_range(0, 7));
        card_in = CW'($urandom_range(0, 63));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_ready();
    fs_en = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
